operand_mux_pipe: RTL and testbench

- Parametrised N-way, WIDTH-bit operand selector for the datapath, with a registered 2-entry elastic output buffer and valid/ready handshakes on both sides.
- Two modes: direct select, where the caller picks the channel, and round-robin, where an internal pointer steps through the channels.
- Sits between the register-file read ports and the ALU/execute stage, where more than two operand sources exist and back-pressure is needed.

---
 rtl/operand_mux_pipe.sv | 127 ++++++++++++
 tb/tb_operand_mux_pipe.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/operand_mux_pipe.sv
// N-way operand selector with direct or round-robin channel choice, feeding a
// registered two-entry elastic buffer with valid/ready on both sides.
module operand_mux_pipe #(
  parameter  int WIDTH  = 32,
  parameter  int NUM_IN = 4,
  localparam int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    mode,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_chan,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_IN - 1);

  logic [1:0]       r_count, w_count_next;
  logic [SEL_W-1:0] r_rr_ptr, w_rr_ptr_next;

  // Entry 0 is always the head; entry 1 only holds data when count is 2.
  logic [WIDTH-1:0] r_data0, r_data1, w_data0_next, w_data1_next;
  logic [SEL_W-1:0] r_chan0, r_chan1, w_chan0_next, w_chan1_next;
  logic             r_err0, r_err1, w_err0_next, w_err1_next;

  logic [WIDTH-1:0] w_chan_data [NUM_IN];
  logic [SEL_W-1:0] w_ch;
  logic             w_oob;
  logic [WIDTH-1:0] w_new_data;
  logic             w_push, w_pop;

  for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_chan
    assign w_chan_data[gi] = in_data[gi*WIDTH +: WIDTH];
  end

  assign w_ch       = mode ? r_rr_ptr : in_sel;
  // Out-of-range selects only exist when NUM_IN is not a power of two.
  assign w_oob      = !mode && (32'(in_sel) >= 32'(NUM_IN));
  assign w_new_data = w_oob ? '0 : w_chan_data[w_ch];

  assign in_ready  = (r_count != 2'd2);
  assign out_valid = (r_count != 2'd0);
  assign out_data  = r_data0;
  assign out_chan  = r_chan0;
  assign out_err   = r_err0;

  assign w_push = in_valid && in_ready;
  assign w_pop  = out_valid && out_ready;

  always_comb begin
    w_count_next  = r_count;
    w_rr_ptr_next = r_rr_ptr;
    w_data0_next  = r_data0;
    w_chan0_next  = r_chan0;
    w_err0_next   = r_err0;
    w_data1_next  = r_data1;
    w_chan1_next  = r_chan1;
    w_err1_next   = r_err1;

    if (w_push && mode) begin
      w_rr_ptr_next = (r_rr_ptr == LAST_CH) ? '0 : r_rr_ptr + 1'b1;
    end

    case (r_count)
      2'd0: begin
        if (w_push) begin
          w_data0_next = w_new_data;
          w_chan0_next = w_ch;
          w_err0_next  = w_oob;
          w_count_next = 2'd1;
        end
      end
      2'd1: begin
        if (w_push && w_pop) begin
          w_data0_next = w_new_data;
          w_chan0_next = w_ch;
          w_err0_next  = w_oob;
        end else if (w_push) begin
          w_data1_next = w_new_data;
          w_chan1_next = w_ch;
          w_err1_next  = w_oob;
          w_count_next = 2'd2;
        end else if (w_pop) begin
          w_count_next = 2'd0;
        end
      end
      default: begin
        // Full: in_ready is low, so only a pop can happen here.
        if (w_pop) begin
          w_data0_next = r_data1;
          w_chan0_next = r_chan1;
          w_err0_next  = r_err1;
          w_count_next = 2'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count  <= '0;
      r_rr_ptr <= '0;
      r_data0  <= '0;
      r_chan0  <= '0;
      r_err0   <= 1'b0;
      r_data1  <= '0;
      r_chan1  <= '0;
      r_err1   <= 1'b0;
    end else begin
      r_count  <= w_count_next;
      r_rr_ptr <= w_rr_ptr_next;
      r_data0  <= w_data0_next;
      r_chan0  <= w_chan0_next;
      r_err0   <= w_err0_next;
      r_data1  <= w_data1_next;
      r_chan1  <= w_chan1_next;
      r_err1   <= w_err1_next;
    end
  end

endmodule

// File: tb/tb_operand_mux_pipe.sv
// Directed bench: a 4-channel instance for the main behaviour and a 3-channel
// instance for out-of-range selects, 3-way wrap and reset mid-stream.
module tb_operand_mux_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int num_checks = 0;
  int num_fails  = 0;

  // 4-channel instance
  logic         a_reset, a_mode, a_in_valid, a_in_ready, a_out_err, a_out_valid, a_out_ready;
  logic [127:0] a_in_data;
  logic [1:0]   a_in_sel, a_out_chan;
  logic [31:0]  a_out_data;

  // 3-channel instance
  logic         b_reset, b_mode, b_in_valid, b_in_ready, b_out_err, b_out_valid, b_out_ready;
  logic [95:0]  b_in_data;
  logic [1:0]   b_in_sel, b_out_chan;
  logic [31:0]  b_out_data;

  operand_mux_pipe #(.WIDTH(32), .NUM_IN(4)) u_dut_a (
    .clk(clk), .reset(a_reset), .in_data(a_in_data), .in_sel(a_in_sel),
    .mode(a_mode), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_data(a_out_data), .out_chan(a_out_chan), .out_err(a_out_err),
    .out_valid(a_out_valid), .out_ready(a_out_ready)
  );

  operand_mux_pipe #(.WIDTH(32), .NUM_IN(3)) u_dut_b (
    .clk(clk), .reset(b_reset), .in_data(b_in_data), .in_sel(b_in_sel),
    .mode(b_mode), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_chan(b_out_chan), .out_err(b_out_err),
    .out_valid(b_out_valid), .out_ready(b_out_ready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    num_checks++;
    if (obs !== exp) begin
      num_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // Advance one edge and settle; inputs set after this take effect at the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    a_in_data   = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    a_reset     = 1'b1;
    a_mode      = 1'b1;
    a_in_sel    = 2'd0;
    a_in_valid  = 1'b1;
    a_out_ready = 1'b0;
    b_in_data   = {32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};
    b_reset     = 1'b1;
    b_mode      = 1'b0;
    b_in_sel    = 2'd0;
    b_in_valid  = 1'b0;
    b_out_ready = 1'b0;

    // Reset with in_valid held high
    step();
    step();
    check("rst_out_valid", 64'(a_out_valid), 64'd0);
    check("rst_out_data",  64'(a_out_data),  64'd0);
    check("rst_out_chan",  64'(a_out_chan),  64'd0);
    check("rst_out_err",   64'(a_out_err),   64'd0);
    check("rst_in_ready",  64'(a_in_ready),  64'd1);
    a_reset = 1'b0;
    step();
    a_in_valid = 1'b0;
    check("rst_rr_valid", 64'(a_out_valid), 64'd1);
    check("rst_rr_chan",  64'(a_out_chan),  64'd0);
    check("rst_rr_data",  64'(a_out_data),  64'h11111111);
    a_out_ready = 1'b1;
    step();
    check("drain0_valid", 64'(a_out_valid), 64'd0);

    // Direct select
    a_mode = 1'b0; a_in_sel = 2'd2; a_in_valid = 1'b1;
    step();
    a_in_valid = 1'b0;
    check("dir_valid", 64'(a_out_valid), 64'd1);
    check("dir_data",  64'(a_out_data),  64'h33333333);
    check("dir_chan",  64'(a_out_chan),  64'd2);
    check("dir_err",   64'(a_out_err),   64'd0);
    step();
    check("dir_empty_valid", 64'(a_out_valid), 64'd0);
    check("dir_hold_data",   64'(a_out_data),  64'h33333333);

    // Fresh reset so the round-robin pointer starts at 0
    a_reset = 1'b1;
    step();
    a_reset = 1'b0;
    a_mode = 1'b1; a_in_valid = 1'b1; a_out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("rr%0d_valid", i), 64'(a_out_valid), 64'd1);
      check($sformatf("rr%0d_chan", i),  64'(a_out_chan),  64'(i % 4));
      check($sformatf("rr%0d_data", i),  64'(a_out_data),  64'((i % 4) + 1) * 64'h11111111);
      check($sformatf("rr%0d_ready", i), 64'(a_in_ready),  64'd1);
    end
    a_in_valid = 1'b0;
    step();
    check("rr_drain_valid", 64'(a_out_valid), 64'd0);

    // Pointer (now 2) holds across a direct-mode push
    a_mode = 1'b0; a_in_sel = 2'd0; a_in_valid = 1'b1;
    step();
    check("hold_dir_chan", 64'(a_out_chan), 64'd0);
    a_mode = 1'b1;
    step();
    check("hold_rr_chan", 64'(a_out_chan), 64'd2);
    check("hold_rr_data", 64'(a_out_data), 64'h33333333);
    a_in_valid = 1'b0;
    step();
    check("hold_drain_valid", 64'(a_out_valid), 64'd0);

    // Back-pressure: fill, stall a third offer, then drain in order
    a_mode = 1'b0; a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_sel = 2'd1;
    step();
    check("bp1_data",  64'(a_out_data), 64'h22222222);
    check("bp1_ready", 64'(a_in_ready), 64'd1);
    a_in_sel = 2'd3;
    step();
    check("bp2_ready", 64'(a_in_ready), 64'd0);
    check("bp2_data",  64'(a_out_data), 64'h22222222);
    a_in_sel = 2'd0;
    a_in_data[63:32] = 32'hDEADBEEF;
    step();
    check("bp3_ready", 64'(a_in_ready), 64'd0);
    check("bp3_data",  64'(a_out_data), 64'h22222222);
    check("bp3_chan",  64'(a_out_chan), 64'd1);
    a_in_valid = 1'b0;
    a_in_data[63:32] = 32'h22222222;
    a_out_ready = 1'b1;
    step();
    check("bp_pop1_valid", 64'(a_out_valid), 64'd1);
    check("bp_pop1_data",  64'(a_out_data),  64'h44444444);
    check("bp_pop1_chan",  64'(a_out_chan),  64'd3);
    check("bp_pop1_ready", 64'(a_in_ready),  64'd1);
    step();
    check("bp_pop2_valid", 64'(a_out_valid), 64'd0);
    check("bp_pop2_data",  64'(a_out_data),  64'h44444444);

    // 3-channel instance: out-of-range select
    step();
    b_reset = 1'b0;
    b_mode = 1'b0; b_in_sel = 2'd3; b_in_valid = 1'b1; b_out_ready = 1'b1;
    step();
    check("oob_valid", 64'(b_out_valid), 64'd1);
    check("oob_data",  64'(b_out_data),  64'd0);
    check("oob_chan",  64'(b_out_chan),  64'd3);
    check("oob_err",   64'(b_out_err),   64'd1);
    b_in_sel = 2'd1;
    step();
    check("b_sel1_data", 64'(b_out_data), 64'hBBBBBBBB);
    check("b_sel1_err",  64'(b_out_err),  64'd0);

    // Fill then reset: buffered entries must vanish
    b_out_ready = 1'b0; b_in_sel = 2'd2;
    step();
    check("b_full_ready", 64'(b_in_ready), 64'd0);
    b_in_valid = 1'b0; b_reset = 1'b1;
    step();
    b_reset = 1'b0; b_out_ready = 1'b1;
    check("b_rst_valid", 64'(b_out_valid), 64'd0);
    check("b_rst_data",  64'(b_out_data),  64'd0);
    check("b_rst_ready", 64'(b_in_ready),  64'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("b_post_rst%0d_valid", i), 64'(b_out_valid), 64'd0);
    end

    // 3-way round-robin wrap
    b_mode = 1'b1; b_in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("b_rr%0d_chan", i), 64'(b_out_chan), 64'(i % 3));
      check($sformatf("b_rr%0d_data", i), 64'(b_out_data), 64'((i % 3) + 10) * 64'h11111111);
    end
    b_in_valid = 1'b0;
    step();
    check("b_rr_drain_valid", 64'(b_out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", num_checks, num_fails);
    $finish;
  end

endmodule
